// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: synchronises the release of the board reset, then
// de-asserts N_OUT active-low reset outputs one after another at programmable
// spacing. Per-channel hold inputs stall the release of the current channel,
// and a software request re-runs the whole sequence after a fixed low pulse.
//
// Optional build macro RST_SEQ_CNT_EN adds rst_cnt_o, a saturating count of
// software reset entries since the last rst_n assertion.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_WAIT  | counting toward the release of channel idx
// ST_DONE  | all channels released, waiting for sw_rst_req
// ST_SWRST | software reset pulse in progress, outputs low
module rst_seq_gen #(
    parameter int N_OUT       = 2,
    parameter int DLY_W       = 8,
    parameter int DLY0        = 5,
    parameter int STEP        = 5,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    input  logic [N_OUT-1:0] hold_i,
    output logic [N_OUT-1:0] rst_n_o,
`ifdef RST_SEQ_CNT_EN
    output logic [7:0]       rst_cnt_o,
`endif
    output logic             seq_done_o,
    output logic             busy_o
);

    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [DLY_W-1:0] DLY0_C  = DLY0[DLY_W-1:0];
    localparam logic [DLY_W-1:0] STEP_C  = STEP[DLY_W-1:0];
    localparam logic [DLY_W-1:0] PULSE_C = PULSE_LEN[DLY_W-1:0];
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(N_OUT - 1);

    // Parameter range checks at elaboration.
    if (DLY0 < 1 || DLY0 >= (1 << DLY_W)) begin : g_chk_dly0
        $error("rst_seq_gen: DLY0 must be in 1..2^DLY_W-1");
    end
    if (STEP < 1 || STEP >= (1 << DLY_W)) begin : g_chk_step
        $error("rst_seq_gen: STEP must be in 1..2^DLY_W-1");
    end
    if (PULSE_LEN < 1 || PULSE_LEN >= (1 << DLY_W)) begin : g_chk_pulse
        $error("rst_seq_gen: PULSE_LEN must be in 1..2^DLY_W-1");
    end
    if (N_OUT < 1 || N_OUT > 16) begin : g_chk_nout
        $error("rst_seq_gen: N_OUT must be in 1..16");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_sync
        $error("rst_seq_gen: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_DONE  = 2'd1,
        ST_SWRST = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DLY_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_OUT-1:0]       rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   rst_sync;
    logic [DLY_W-1:0]       cnt_inc;
    logic [DLY_W-1:0]       target;
    logic                   hold_cur;

    assign rst_sync = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = cnt_q + 1'b1;
    assign target   = (idx_q == '0) ? DLY0_C : STEP_C;
    assign hold_cur = hold_i[idx_q];

    // Release synchroniser: async clear, shifts in ones after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; a held channel parks the counter at target-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        busy_d  = busy_q;

        case (state_q)
            ST_WAIT: begin
                if (!rst_sync) begin
                    cnt_d = '0;
                end else if (cnt_inc == target) begin
                    if (!hold_cur) begin
                        rst_d[idx_q] = 1'b1;
                        cnt_d        = '0;
                        if (idx_q == LAST_C) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (sw_rst_req) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SWRST;
                end
            end
            ST_SWRST: begin
                if (cnt_inc == PULSE_C) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '0;
                done_d  = 1'b0;
                busy_d  = 1'b1;
            end
        endcase
    end

    assign rst_n_o    = rst_q;
    assign seq_done_o = done_q;
    assign busy_o     = busy_q;

`ifdef RST_SEQ_CNT_EN
    logic [7:0] rst_cnt_q;

    // Saturating count of software reset entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q <= '0;
        end else if (state_q == ST_DONE && sw_rst_req && rst_cnt_q != 8'hFF) begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
        end
    end

    assign rst_cnt_o = rst_cnt_q;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: a 3-channel instance (DLY0=4, STEP=3,
// PULSE_LEN=6) and a degenerate 1-channel instance (DLY0=1) share clk/rst_n.
module tb_rst_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_rst_req;
    logic [2:0] hold_i;
    logic [2:0] rst_n_o;
    logic       seq_done_o;
    logic       busy_o;
    logic       dg_rst_n_o;
    logic       dg_done_o;
    logic       dg_busy_o;
`ifdef RST_SEQ_CNT_EN
    logic [7:0] rst_cnt_o;
    logic [7:0] dg_cnt_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rst_seq_gen #(
        .N_OUT(3), .DLY_W(8), .DLY0(4), .STEP(3), .SYNC_STAGES(2), .PULSE_LEN(6)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .hold_i     (hold_i),
        .rst_n_o    (rst_n_o),
`ifdef RST_SEQ_CNT_EN
        .rst_cnt_o  (rst_cnt_o),
`endif
        .seq_done_o (seq_done_o),
        .busy_o     (busy_o)
    );

    rst_seq_gen #(
        .N_OUT(1), .DLY_W(8), .DLY0(1), .STEP(5), .SYNC_STAGES(2), .PULSE_LEN(8)
    ) u_dg (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (1'b0),
        .hold_i     (1'b0),
        .rst_n_o    (dg_rst_n_o),
`ifdef RST_SEQ_CNT_EN
        .rst_cnt_o  (dg_cnt_o),
`endif
        .seq_done_o (dg_done_o),
        .busy_o     (dg_busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge e is the e-th clk edge after the call. Channel k of the main
    // instance is expected high from edge tk on; the degenerate instance from
    // dg_t on. sw_rst_req is high only when sampled at edges sw_a / sw_b, and
    // hold_i[1] is high when sampled at edges 1..hold_last.
    task automatic check_seq(input int t0, input int t1, input int t2, input int dg_t,
                             input int sw_a, input int sw_b, input int hold_last,
                             input int n);
        logic [2:0] exp;
        sw_rst_req = (sw_a == 1) || (sw_b == 1);
        hold_i     = {1'b0, (hold_last >= 1), 1'b0};
        for (int e = 1; e <= n; e++) begin
            tick();
            exp = {(e >= t2), (e >= t1), (e >= t0)};
            chk($sformatf("rst_n_o@%0d", e), 32'(rst_n_o), 32'(exp));
            chk($sformatf("seq_done_o@%0d", e), 32'(seq_done_o), 32'(e >= t2));
            chk($sformatf("busy_o@%0d", e), 32'(busy_o), 32'(e < t2));
            chk($sformatf("dg_rst_n_o@%0d", e), 32'(dg_rst_n_o), 32'(e >= dg_t));
            chk($sformatf("dg_done_o@%0d", e), 32'(dg_done_o), 32'(e >= dg_t));
            sw_rst_req = ((e + 1) == sw_a) || ((e + 1) == sw_b);
            hold_i[1]  = ((e + 1) <= hold_last);
        end
        sw_rst_req = 1'b0;
        hold_i     = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        hold_i     = '0;

        // Reset values
        repeat (3) tick();
        chk("reset rst_n_o", 32'(rst_n_o), 32'h0);
        chk("reset seq_done_o", 32'(seq_done_o), 32'h0);
        chk("reset busy_o", 32'(busy_o), 32'h1);
        chk("reset dg_rst_n_o", 32'(dg_rst_n_o), 32'h0);
        chk("reset dg_busy_o", 32'(dg_busy_o), 32'h1);

        // Power-on: channels at edges 6/9/12, degenerate at edge 3
        rst_n = 1'b1;
        check_seq(6, 9, 12, 3, 0, 0, 0, 14);
        chk("dg_busy_o after release", 32'(dg_busy_o), 32'h0);

        // Software reset from DONE (sampled at edge 1), a second request
        // during the pulse (edge 4) must be ignored: WAIT at 7, ch0 at 11
        check_seq(11, 14, 17, 0, 1, 4, 0, 19);
`ifdef RST_SEQ_CNT_EN
        chk("rst_cnt_o after one swrst", 32'(rst_cnt_o), 32'd1);
`endif

        // Async assertion from DONE, no clock edge
        rst_n = 1'b0;
        #1;
        chk("async rst_n_o from DONE", 32'(rst_n_o), 32'h0);
        chk("async busy_o from DONE", 32'(busy_o), 32'h1);
        chk("async dg_rst_n_o from DONE", 32'(dg_rst_n_o), 32'h0);
        repeat (2) tick();

        // Abort between channel 0 and channel 1 releases
        rst_n = 1'b1;
        check_seq(6, 9, 12, 3, 0, 0, 0, 7);
        rst_n = 1'b0;
        #1;
        chk("abort rst_n_o", 32'(rst_n_o), 32'h0);
        chk("abort seq_done_o", 32'(seq_done_o), 32'h0);
        chk("abort busy_o", 32'(busy_o), 32'h1);
        chk("abort dg_rst_n_o", 32'(dg_rst_n_o), 32'h0);
`ifdef RST_SEQ_CNT_EN
        chk("rst_cnt_o cleared by rst_n", 32'(rst_cnt_o), 32'd0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        check_seq(6, 9, 12, 3, 0, 0, 0, 14);

        // Hold on channel 1 through edge 15: releases at 16, channel 2 at 19
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check_seq(6, 16, 19, 3, 0, 0, 15, 21);

`ifdef RST_SEQ_CNT_EN
        // Three software resets counted, then cleared by rst_n
        chk("rst_cnt_o before swrst", 32'(rst_cnt_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_seq(11, 14, 17, 0, 1, 0, 0, 19);
        end
        chk("rst_cnt_o after three swrst", 32'(rst_cnt_o), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_cnt_o after rst_n", 32'(rst_cnt_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
